cpu_run_ctrl: RTL and testbench

- Synthesizable run controller and trace capture unit for the single-cycle CPU.
- Drives the CPU `start` input and ends a run on one of three conditions: halt instruction, PC stall, or cycle timeout.
- Records one trace entry per retired PC into a FIFO; the entry holds pc, instr and NUM_WATCH watched registers.
- Replaces the fixed-duration, $monitor-based bring-up; a downstream consumer (UART/debug port) drains the FIFO with a valid/ready handshake.

---
 rtl/cpu_run_pkg.sv | 29 ++
 rtl/cpu_run_ctrl_fifo.sv | 64 ++++++
 rtl/cpu_run_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run controller: run states, stop-cause
// codes, the default halt encoding and the stop-cause priority helper.
package cpu_run_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } run_state_e;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_HALT    = 2'd1;
   localparam logic [1:0] CAUSE_STALL   = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

   localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000000C;

   // Halt wins over stall, stall wins over timeout.
   function automatic logic [1:0] stop_cause(input logic halt, input logic stall);
      if (halt)
         return CAUSE_HALT;
      else if (stall)
         return CAUSE_STALL;
      else
         return CAUSE_TIMEOUT;
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_fifo.sv
// trace_fifo: show-ahead FIFO holding trace entries. The head entry is
// visible the cycle after it is written into an empty FIFO and stays stable
// until popped. A push into a full FIFO without a simultaneous pop is dropped
// and reported with a one-cycle overflow pulse.
module trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   output logic             valid,
   input  logic             ready,
   output logic [WIDTH-1:0] head_data,
   output logic             overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign valid     = (count_reg != '0);
   assign full      = (count_reg == FULL_COUNT);
   assign do_pop    = valid && ready;
   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign do_push   = push && (!full || do_pop);
   assign overflow  = push && full && !do_pop;
   assign head_data = mem[rd_ptr_reg];

   // Entry storage; contents are meaningless until counted, so no reset.
   always_ff @(posedge clock) begin
      if (do_push)
         mem[wr_ptr_reg] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: starts a CPU run, ends it on halt / pc stall / timeout and
// captures one trace entry per retired pc into trace_fifo for a downstream
// consumer. Optional macro CPU_RUN_CTRL_REGDIFF_EN adds a per-entry
// register-change mask (trace_diff_mask) and also pushes when only watched
// registers change.
module cpu_run_ctrl
   import cpu_run_pkg::*;
#(
   parameter int PC_WIDTH    = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_WATCH   = 4,
   parameter int TRACE_DEPTH = 16,
   parameter int MAX_CYCLES  = 60,
   parameter int STALL_LIMIT = 4,
   parameter logic [INSTR_WIDTH-1:0] HALT_INSTR = INSTR_WIDTH'(DEFAULT_HALT_INSTR)
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              go,
   output logic                              cpu_start,
   input  logic [PC_WIDTH-1:0]               pc,
   input  logic [INSTR_WIDTH-1:0]            instr,
   input  logic [NUM_WATCH*DATA_WIDTH-1:0]   watch_regs,
   output logic                              trace_valid,
   input  logic                              trace_ready,
   output logic [PC_WIDTH-1:0]               trace_pc,
   output logic [INSTR_WIDTH-1:0]            trace_instr,
   output logic [NUM_WATCH*DATA_WIDTH-1:0]   trace_regs,
   output logic                              busy,
   output logic                              done,
   output logic [1:0]                        done_cause,
   output logic [$clog2(MAX_CYCLES+1)-1:0]   cycle_count,
`ifdef CPU_RUN_CTRL_REGDIFF_EN
   output logic [NUM_WATCH-1:0]              trace_diff_mask,
`endif
   output logic                              trace_overflow
);

   localparam int CC_W   = $clog2(MAX_CYCLES+1);
   localparam int SC_W   = $clog2(STALL_LIMIT+1);
   localparam int REGS_W = NUM_WATCH*DATA_WIDTH;
`ifdef CPU_RUN_CTRL_REGDIFF_EN
   localparam int ENTRY_W = PC_WIDTH + INSTR_WIDTH + REGS_W + NUM_WATCH;
`else
   localparam int ENTRY_W = PC_WIDTH + INSTR_WIDTH + REGS_W;
`endif

   run_state_e          state_reg, state_next;
   logic [CC_W-1:0]     cycle_reg;
   logic [SC_W-1:0]     stall_reg;
   logic [PC_WIDTH-1:0] prev_pc_reg;
   logic                first_reg;
   logic [1:0]          cause_reg;
   logic                overflow_reg;

   logic                start_run;
   logic                in_run;
   logic                pc_same;
   logic                halt_hit;
   logic                stall_hit;
   logic                timeout_hit;
   logic                stop;
   logic                push;
   logic [ENTRY_W-1:0]  push_data;
   logic [ENTRY_W-1:0]  head_data;
   logic                fifo_full;
   logic                fifo_valid;
   logic                fifo_overflow;

   assign start_run   = go && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
   assign in_run      = (state_reg == ST_RUN);
   assign pc_same     = !first_reg && (pc == prev_pc_reg);
   assign halt_hit    = (instr == HALT_INSTR);
   assign stall_hit   = (stall_reg == SC_W'(STALL_LIMIT-1));
   assign timeout_hit = (cycle_reg == CC_W'(MAX_CYCLES-1));
   assign stop        = in_run && (halt_hit || stall_hit || timeout_hit);

`ifdef CPU_RUN_CTRL_REGDIFF_EN
   logic [REGS_W-1:0]    prev_regs_reg;
   logic [NUM_WATCH-1:0] diff_mask;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WATCH; gi++) begin : g_diff
         assign diff_mask[gi] = first_reg ||
            (watch_regs[gi*DATA_WIDTH +: DATA_WIDTH] != prev_regs_reg[gi*DATA_WIDTH +: DATA_WIDTH]);
      end
   endgenerate

   assign push      = in_run && (first_reg || !pc_same || (diff_mask != '0));
   assign push_data = {pc, instr, watch_regs, diff_mask};
   assign {trace_pc, trace_instr, trace_regs, trace_diff_mask} = head_data;

   // Remember the registers of the last pushed entry for change detection.
   always_ff @(posedge clock) begin
      if (reset)
         prev_regs_reg <= '0;
      else if (push)
         prev_regs_reg <= watch_regs;
   end
`else
   assign push      = in_run && (first_reg || !pc_same);
   assign push_data = {pc, instr, watch_regs};
   assign {trace_pc, trace_instr, trace_regs} = head_data;
`endif

   // Flushed on reset and at the start of every run.
   trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (TRACE_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .clear     (start_run),
      .push      (push),
      .push_data (push_data),
      .full      (fifo_full),
      .valid     (fifo_valid),
      .ready     (trace_ready),
      .head_data (head_data),
      .overflow  (fifo_overflow)
   );

   // Next-state selection for the run sequence.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: if (go)          state_next = ST_RUN;
         ST_RUN:           if (stop)        state_next = ST_DRAIN;
         ST_DRAIN:         if (!fifo_valid) state_next = ST_DONE;
         default:                           state_next = ST_IDLE;
      endcase
   end

   // Run bookkeeping: counters, stop cause and sticky overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         cycle_reg    <= '0;
         stall_reg    <= '0;
         prev_pc_reg  <= '0;
         first_reg    <= 1'b0;
         cause_reg    <= CAUSE_NONE;
         overflow_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (start_run) begin
            cycle_reg    <= '0;
            stall_reg    <= '0;
            prev_pc_reg  <= '0;
            first_reg    <= 1'b1;
            cause_reg    <= CAUSE_NONE;
            overflow_reg <= 1'b0;
         end else begin
            if (in_run) begin
               first_reg   <= 1'b0;
               prev_pc_reg <= pc;
               if (!pc_same)
                  stall_reg <= '0;
               else if (stall_reg != '1)
                  stall_reg <= stall_reg + SC_W'(1);
               // The count freezes on the stopping cycle.
               if (stop)
                  cause_reg <= stop_cause(halt_hit, stall_hit);
               else if (cycle_reg != '1)
                  cycle_reg <= cycle_reg + CC_W'(1);
            end
            if (fifo_overflow)
               overflow_reg <= 1'b1;
         end
      end
   end

   assign cpu_start      = (state_reg == ST_RUN);
   assign busy           = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
   assign done           = (state_reg == ST_DONE);
   assign done_cause     = cause_reg;
   assign cycle_count    = cycle_reg;
   assign trace_valid    = fifo_valid;
   assign trace_overflow = overflow_reg;

   // fifo_full is informational here; overflow reporting comes from the FIFO.
   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl (default build). A cycle-stepped behavioural
// model (queue of expected entries plus run bookkeeping in plain integers)
// is compared against the DUT on every cycle, and literal expectations pin
// the outcome of each directed run.
module tb_cpu_run_ctrl;
   import cpu_run_pkg::*;

   localparam int DW = 32;
   localparam int NW = 4;
   localparam int RW = NW*DW;
   localparam int TD = 16;
   localparam int MC = 60;
   localparam int SL = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          go;
   logic          cpu_start;
   logic [31:0]   pc;
   logic [31:0]   instr;
   logic [RW-1:0] watch_regs;
   logic          trace_valid;
   logic          trace_ready;
   logic [31:0]   trace_pc;
   logic [31:0]   trace_instr;
   logic [RW-1:0] trace_regs;
   logic          busy;
   logic          done;
   logic [1:0]    done_cause;
   logic [5:0]    cycle_count;
   logic          trace_overflow;
`ifdef CPU_RUN_CTRL_REGDIFF_EN
   logic [NW-1:0] trace_diff_mask;
`endif

   always #5 clock = ~clock;

   cpu_run_ctrl dut (
      .clock          (clock),
      .reset          (reset),
      .go             (go),
      .cpu_start      (cpu_start),
      .pc             (pc),
      .instr          (instr),
      .watch_regs     (watch_regs),
      .trace_valid    (trace_valid),
      .trace_ready    (trace_ready),
      .trace_pc       (trace_pc),
      .trace_instr    (trace_instr),
      .trace_regs     (trace_regs),
      .busy           (busy),
      .done           (done),
      .done_cause     (done_cause),
      .cycle_count    (cycle_count),
`ifdef CPU_RUN_CTRL_REGDIFF_EN
      .trace_diff_mask(trace_diff_mask),
`endif
      .trace_overflow (trace_overflow)
   );

   typedef struct {
      logic [31:0]   pc;
      logic [31:0]   instr;
      logic [RW-1:0] regs;
   } ent_t;

   // Model: phase 0 idle, 1 running, 2 draining, 3 finished.
   ent_t        exp_q[$];
   int          m_phase = 0;
   int          m_k = 0;
   int          m_cause = 0;
   int          m_same = 0;
   bit          m_ovf = 1'b0;
   logic [31:0] m_prev = '0;
   bit          model_ok = 1'b0;

   logic [31:0] popped[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          mode = 0;   // 0 halt program, 1 stuck pc, 2 pc += 4

   task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Bench-side CPU stand-in: pc/instr/regs depend only on the run cycle index.
   task automatic drive_cpu();
      if (m_phase == 1) begin
         case (mode)
            0: begin
               pc    = 32'(4*m_k);
               instr = (m_k == 3) ? 32'h0000000C : 32'h13 + 32'(m_k << 7);
            end
            1: begin
               pc    = 32'h10;
               instr = 32'h13;
            end
            default: begin
               pc    = 32'(4*m_k);
               instr = 32'h13;
            end
         endcase
         for (int i = 0; i < NW; i++)
            watch_regs[i*DW +: DW] = 32'hA000_0000 | 32'(m_k << 8) | 32'(i);
      end else begin
         pc         = 32'hFFFF_FFF0;
         instr      = '0;
         watch_regs = '0;
      end
   endtask

   task automatic compare();
      chk("cpu_start", {127'd0, cpu_start}, {127'd0, m_phase == 1});
      chk("busy", {127'd0, busy}, {127'd0, (m_phase == 1) || (m_phase == 2)});
      chk("done", {127'd0, done}, {127'd0, m_phase == 3});
      chk("done_cause", RW'(done_cause), RW'(m_cause));
      chk("cycle_count", RW'(cycle_count), RW'(m_k));
      chk("trace_overflow", {127'd0, trace_overflow}, {127'd0, m_ovf});
      chk("trace_valid", {127'd0, trace_valid}, {127'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
         chk("head_pc", RW'(trace_pc), RW'(exp_q[0].pc));
         chk("head_instr", RW'(trace_instr), RW'(exp_q[0].instr));
         chk("head_regs", trace_regs, exp_q[0].regs);
      end
      if (trace_valid && trace_ready) begin
         popped.push_back(trace_pc);
         $display("[TB] pop pc=%h instr=%h cyc=%0d", trace_pc, trace_instr, cyc);
      end
   endtask

   task automatic model_step();
      int   size_before;
      bit   push, halt_c, stall_c, to_c;
      ent_t e;
      if (reset) begin
         m_phase = 0; m_k = 0; m_cause = 0; m_same = 0; m_ovf = 1'b0; m_prev = '0;
         exp_q.delete();
         return;
      end
      size_before = exp_q.size();
      if (size_before != 0 && trace_ready)
         void'(exp_q.pop_front());
      case (m_phase)
         0, 3: begin
            if (go) begin
               m_phase = 1; m_k = 0; m_cause = 0; m_same = 0; m_ovf = 1'b0;
               exp_q.delete();
            end
         end
         1: begin
            push = (m_k == 0) || (pc != m_prev);
            if (push) begin
               if (exp_q.size() < TD) begin
                  e.pc = pc; e.instr = instr; e.regs = watch_regs;
                  exp_q.push_back(e);
               end else begin
                  m_ovf = 1'b1;
               end
            end
            halt_c  = (instr == 32'h0000000C);
            stall_c = (m_same == SL-1);
            to_c    = (m_k == MC-1);
            m_same  = (m_k > 0 && pc == m_prev) ? m_same + 1 : 0;
            m_prev  = pc;
            if (halt_c || stall_c || to_c) begin
               m_cause = halt_c ? 1 : (stall_c ? 2 : 3);
               m_phase = 2;
            end else begin
               m_k++;
            end
         end
         default: begin
            if (size_before == 0)
               m_phase = 3;
         end
      endcase
   endtask

   task automatic tick();
      @(negedge clock);
      if (model_ok)
         compare();
      model_step();
      model_ok = 1'b1;
      @(posedge clock);
      #1;
      cyc++;
      drive_cpu();
   endtask

   task automatic start_run();
      popped.delete();
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   task automatic run_to_done(input int budget);
      int n;
      n = 0;
      while (m_phase != 3 && n < budget) begin
         tick();
         n++;
      end
      chk("done_reached", {127'd0, done}, {127'd0, 1'b1});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; go = 1'b0; trace_ready = 1'b0;
      drive_cpu();
      tick(); tick();
      reset = 1'b0;
      chk("rst_busy", {127'd0, busy}, '0);
      chk("rst_valid", {127'd0, trace_valid}, '0);
      chk("rst_cycle", RW'(cycle_count), '0);

      // Halt at pc C.
      mode = 0; trace_ready = 1'b1;
      start_run();
      run_to_done(100);
      chk("halt_cause", RW'(done_cause), RW'(2'd1));
      chk("halt_pops", RW'(popped.size()), RW'(4));
      for (int i = 0; i < 4; i++)
         if (i < popped.size()) chk("halt_pc_order", RW'(popped[i]), RW'(32'(4*i)));
      chk("halt_cycle", RW'(cycle_count), RW'(3));

      // Stall at pc 10.
      mode = 1;
      start_run();
      run_to_done(100);
      chk("stall_cause", RW'(done_cause), RW'(2'd2));
      chk("stall_pops", RW'(popped.size()), RW'(1));
      if (popped.size() > 0) chk("stall_pc", RW'(popped[0]), RW'(32'h10));
      chk("stall_cycle", RW'(cycle_count), RW'(4));

      // Timeout with free-running consumer; a go pulse mid-run is ignored.
      mode = 2;
      start_run();
      n = 0;
      while (m_k < 10 && n < 100) begin tick(); n++; end
      go = 1'b1; tick(); go = 1'b0;
      run_to_done(200);
      chk("to_cause", RW'(done_cause), RW'(2'd3));
      chk("to_cycle", RW'(cycle_count), RW'(59));
      chk("to_pops", RW'(popped.size()), RW'(60));
      if (popped.size() == 60) chk("to_last_pc", RW'(popped[59]), RW'(32'hEC));
      chk("to_ovf", {127'd0, trace_overflow}, '0);

      // Backpressure for the whole run: 16 retained, overflow set.
      trace_ready = 1'b0;
      start_run();
      n = 0;
      while (m_phase == 1 && n < 100) begin tick(); n++; end
      for (int i = 0; i < 3; i++) begin
         chk("bp_head_pc", RW'(trace_pc), '0);
         chk("bp_valid", {127'd0, trace_valid}, {127'd0, 1'b1});
         tick();
      end
      chk("bp_ovf", {127'd0, trace_overflow}, {127'd0, 1'b1});
      trace_ready = 1'b1;
      run_to_done(100);
      chk("bp_pops", RW'(popped.size()), RW'(16));
      if (popped.size() == 16) chk("bp_last_pc", RW'(popped[15]), RW'(32'h3C));

      // Restart from DONE, then fill, then push+pop while full.
      trace_ready = 1'b0;
      start_run();
      chk("rs_cycle", RW'(cycle_count), '0);
      chk("rs_done", {127'd0, done}, '0);
      chk("rs_cause", RW'(done_cause), '0);
      chk("rs_ovf", {127'd0, trace_overflow}, '0);
      chk("rs_start", {127'd0, cpu_start}, {127'd0, 1'b1});
      n = 0;
      while (m_k < 20 && n < 100) begin tick(); n++; end
      trace_ready = 1'b1;
      run_to_done(200);
      chk("pf_pops", RW'(popped.size()), RW'(56));
      if (popped.size() > 16) chk("pf_pc16", RW'(popped[16]), RW'(32'h50));
      chk("pf_ovf", {127'd0, trace_overflow}, {127'd1});

      // Reset mid-run with 3 entries queued.
      trace_ready = 1'b0;
      start_run();
      tick(); tick(); tick();
      chk("mr_valid_before", {127'd0, trace_valid}, {127'd0, 1'b1});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_start", {127'd0, cpu_start}, '0);
      chk("mr_busy", {127'd0, busy}, '0);
      chk("mr_done", {127'd0, done}, '0);
      chk("mr_cause", RW'(done_cause), '0);
      chk("mr_cycle", RW'(cycle_count), '0);
      chk("mr_ovf", {127'd0, trace_overflow}, '0);
      chk("mr_valid", {127'd0, trace_valid}, '0);
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
